// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the execute stage and a byte-addressable
// data memory; splits word-crossing accesses into two word cycles.
module lsu_mem_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  we,
    input  logic [31:0] drdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_SECOND = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        st_q, st_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] smask_of(input logic [1:0] sz);
        case (sz)
            2'b00:   smask_of = 4'b0001;
            2'b01:   smask_of = 4'b0011;
            default: smask_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extract(
        input logic [63:0] w,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [63:0] s;
        s = w >> {off, 3'b000};
        case (f3[1:0])
            2'b00:
                extract = f3[2] ? {24'd0, s[7:0]}
                                : {{24{s[7]}}, s[7:0]};
            2'b01:
                extract = f3[2] ? {16'd0, s[15:0]}
                                : {{16{s[15]}}, s[15:0]};
            default:
                extract = s[31:0];
        endcase
    endfunction

    // Legality of the incoming request, evaluated while idle
    logic req_bad_f3;
    logic req_cross;
    logic req_illegal;

    assign req_bad_f3 = req_we
        ? (req_funct3 >= 3'b011)
        : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    assign req_cross =
        (({1'b0, req_addr[1:0]} + size_of(req_funct3[1:0])) > 3'd4);
    assign req_illegal = req_bad_f3 || (req_cross && !ALLOW_MISALIGNED);

    // Lane placement and crossing of the latched request
    logic [63:0] sdata;
    logic [7:0]  mask8;
    logic        cross_q;
    logic [31:0] base;

    assign sdata   = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
    assign mask8   = {4'd0, smask_of(f3_q[1:0])} << addr_q[1:0];
    assign cross_q =
        (({1'b0, addr_q[1:0]} + size_of(f3_q[1:0])) > 3'd4);
    assign base    = {addr_q[31:2], 2'b00};

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = err_q && (state_q == S_RESP);
    assign resp_rdata = rdata_q;

    // Next-state and memory-port drive
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        daddr   = 32'd0;
        dwdata  = 32'd0;
        we      = 4'd0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    st_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_illegal;
                    if (req_illegal) begin
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_FIRST;
                    end
                end
            end
            S_FIRST: begin
                daddr  = base;
                dwdata = sdata[31:0];
                we     = st_q ? mask8[3:0] : 4'd0;
                if (!st_q) lo_d = drdata;
                if (cross_q) begin
                    state_d = S_SECOND;
                end else begin
                    rdata_d = st_q ? 32'd0
                        : extract({32'd0, drdata}, addr_q[1:0], f3_q);
                    state_d = S_RESP;
                end
            end
            S_SECOND: begin
                daddr  = base + 32'd4;
                dwdata = sdata[63:32];
                we     = st_q ? mask8[7:4] : 4'd0;
                if (!st_q) hi_d = drdata;
                rdata_d = st_q ? 32'd0
                    : extract({drdata, lo_q}, addr_q[1:0], f3_q);
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request/buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            st_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
